vram_arbiter: RTL and testbench

Single-port arbiter for the shared video RAM between the Konami-2 CPU bus and the tilemap/sprite fetch engine. It sits behind the bus-control decode and consumes the active-low chip select for the VRAM or OBJ window. Each CLK12 cycle it grants one access, with priority to video fetch and a starvation guard for the CPU. It drives the RAM address, write strobe and data, returns read data to both requesters, and generates the CPU acknowledge (DTACn) that ends the CPU's wait states.

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_slot_pipe.sv | 61 ++++++
 rtl/vram_arbiter.sv | 96 +++++++++
 tb/tb_vram_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: slot tags that travel down the grant pipeline.
package vram_pkg;
    localparam int AW_DEF = 13;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_VID    = 2'd1,
        SLOT_CPU_RD = 2'd2,
        SLOT_CPU_WR = 2'd3
    } slot_t;

    function automatic logic is_cpu(input slot_t t);
        return (t == SLOT_CPU_RD) || (t == SLOT_CPU_WR);
    endfunction
endpackage

// File: rtl/vram_slot_pipe.sv
// Two-stage grant pipeline: stage 1 drives the RAM, stage 2 captures read data.
module vram_slot_pipe
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  slot_t         i_tag,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_din,
    input  logic [7:0]    i_ram_q,
    output slot_t         o_tag1,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_wen,
    output logic [7:0]    o_ram_dout,
    output logic          o_vid_valid,
    output logic [7:0]    o_vid_data,
    output logic [7:0]    o_cpu_dout
);
    slot_t         r_tag1;
    logic [AW-1:0] r_addr;
    logic          r_wen;
    logic [7:0]    r_dout;
    logic          r_vid_valid;
    logic [7:0]    r_vid_data;
    logic [7:0]    r_cpu_dout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag1      <= SLOT_IDLE;
            r_addr      <= '0;
            r_wen       <= 1'b1;
            r_dout      <= 8'h00;
            r_vid_valid <= 1'b0;
            r_vid_data  <= 8'h00;
            r_cpu_dout  <= 8'h00;
        end else begin
            r_tag1 <= i_tag;
            // Address and write data hold through idle slots
            if (i_tag != SLOT_IDLE)
                r_addr <= i_addr;
            r_wen <= (i_tag != SLOT_CPU_WR);
            if (i_tag == SLOT_CPU_WR)
                r_dout <= i_din;
            r_vid_valid <= (r_tag1 == SLOT_VID);
            if (r_tag1 == SLOT_VID)
                r_vid_data <= i_ram_q;
            if (r_tag1 == SLOT_CPU_RD)
                r_cpu_dout <= i_ram_q;
        end
    end

    assign o_tag1      = r_tag1;
    assign o_ram_addr  = r_addr;
    assign o_ram_wen   = r_wen;
    assign o_ram_dout  = r_dout;
    assign o_vid_valid = r_vid_valid;
    assign o_vid_data  = r_vid_data;
    assign o_cpu_dout  = r_cpu_dout;
endmodule

// File: rtl/vram_arbiter.sv
// Shared VRAM arbiter: video fetch has priority, CPU is protected by a starvation
// guard, and the CPU acknowledge is held until the chip select is released.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int MAX_VID = 3
) (
    input  logic          CLK12,
    input  logic          RESET,
    input  logic          CPU_CSn,
    input  logic          CPU_RWb,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [7:0]    CPU_DIN,
    output logic [7:0]    CPU_DOUT,
    output logic          CPU_DTACn,
    input  logic          VID_REQ,
    input  logic [AW-1:0] VID_ADDR,
    output logic          VID_ACK,
    output logic          VID_VALID,
    output logic [7:0]    VID_DATA,
    output logic [AW-1:0] RAM_ADDR,
    output logic          RAM_WEn,
    output logic [7:0]    RAM_DOUT,
    input  logic [7:0]    RAM_Q
);
    localparam logic [2:0] STARVE_MAX = 3'(MAX_VID);

    logic          r_served;
    logic [2:0]    r_starve;
    logic          r_dtacn;
    logic          w_cpu_pend;
    logic          w_cpu_win;
    logic          w_vid_win;
    slot_t         w_tag;
    slot_t         w_tag1;
    logic [AW-1:0] w_addr;

    assign w_cpu_pend = !CPU_CSn && !r_served;
    assign w_cpu_win  = w_cpu_pend && (!VID_REQ || (r_starve == STARVE_MAX));
    assign w_vid_win  = !w_cpu_win && VID_REQ;

    always_comb begin
        w_tag  = SLOT_IDLE;
        w_addr = VID_ADDR;
        if (w_cpu_win) begin
            w_tag  = CPU_RWb ? SLOT_CPU_RD : SLOT_CPU_WR;
            w_addr = CPU_ADDR;
        end else if (w_vid_win) begin
            w_tag = SLOT_VID;
        end
    end

    always_ff @(posedge CLK12 or posedge RESET) begin
        if (RESET) begin
            r_served <= 1'b0;
            r_starve <= 3'd0;
            r_dtacn  <= 1'b1;
        end else begin
            if (CPU_CSn)
                r_served <= 1'b0;
            else if (w_cpu_win)
                r_served <= 1'b1;

            if (!w_cpu_pend || w_cpu_win)
                r_starve <= 3'd0;
            else if (w_vid_win && (r_starve != STARVE_MAX))
                r_starve <= r_starve + 3'd1;

            // A CPU slot leaving stage 1 acknowledges only if CSn is still low
            if (CPU_CSn)
                r_dtacn <= 1'b1;
            else if (is_cpu(w_tag1))
                r_dtacn <= 1'b0;
        end
    end

    vram_slot_pipe #(.AW(AW)) u_pipe (
        .i_clk       (CLK12),
        .i_rst       (RESET),
        .i_tag       (w_tag),
        .i_addr      (w_addr),
        .i_din       (CPU_DIN),
        .i_ram_q     (RAM_Q),
        .o_tag1      (w_tag1),
        .o_ram_addr  (RAM_ADDR),
        .o_ram_wen   (RAM_WEn),
        .o_ram_dout  (RAM_DOUT),
        .o_vid_valid (VID_VALID),
        .o_vid_data  (VID_DATA),
        .o_cpu_dout  (CPU_DOUT)
    );

    assign VID_ACK   = w_vid_win && !RESET;
    assign CPU_DTACn = r_dtacn;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed, table-driven bench for vram_arbiter with a behavioural RAM per instance.
module tb_vram_arbiter;
    logic        CLK12 = 1'b0;
    logic        RESET = 1'b1;
    logic        CPU_CSn = 1'b1;
    logic        CPU_RWb = 1'b1;
    logic [12:0] CPU_ADDR = '0;
    logic [7:0]  CPU_DIN = '0;
    logic        VID_REQ = 1'b0;
    logic [12:0] VID_ADDR = '0;
    logic        do_init = 1'b1;

    logic [7:0]  d0_cpu_dout, d1_cpu_dout, d0_vid_data, d1_vid_data, d0_rdout, d1_rdout, d0_q, d1_q;
    logic        d0_dtacn, d1_dtacn, d0_ack, d1_ack, d0_vv, d1_vv, d0_wen, d1_wen;
    logic [12:0] d0_raddr, d1_raddr;
    logic [7:0]  mem0 [0:8191];
    logic [7:0]  mem1 [0:8191];

    always #5 CLK12 = ~CLK12;

    vram_arbiter #(.AW(13), .MAX_VID(3)) u_dut0 (
        .CLK12(CLK12), .RESET(RESET), .CPU_CSn(CPU_CSn), .CPU_RWb(CPU_RWb),
        .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_DOUT(d0_cpu_dout), .CPU_DTACn(d0_dtacn),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_ACK(d0_ack), .VID_VALID(d0_vv),
        .VID_DATA(d0_vid_data), .RAM_ADDR(d0_raddr), .RAM_WEn(d0_wen), .RAM_DOUT(d0_rdout),
        .RAM_Q(d0_q));

    vram_arbiter #(.AW(13), .MAX_VID(1)) u_dut1 (
        .CLK12(CLK12), .RESET(RESET), .CPU_CSn(CPU_CSn), .CPU_RWb(CPU_RWb),
        .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_DOUT(d1_cpu_dout), .CPU_DTACn(d1_dtacn),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_ACK(d1_ack), .VID_VALID(d1_vv),
        .VID_DATA(d1_vid_data), .RAM_ADDR(d1_raddr), .RAM_WEn(d1_wen), .RAM_DOUT(d1_rdout),
        .RAM_Q(d1_q));

    assign d0_q = mem0[d0_raddr];
    assign d1_q = mem1[d1_raddr];

    always @(posedge CLK12) begin
        if (do_init) begin
            mem0[13'h0123] <= 8'h5A; mem0[13'h0456] <= 8'h3C; mem0[13'h0AAA] <= 8'hC3;
            mem0[13'h0010] <= 8'h00; mem0[13'h0020] <= 8'h00; mem0[13'h0030] <= 8'h00;
            mem0[13'h1FFF] <= 8'h00;
        end else if (!d0_wen) begin
            mem0[d0_raddr] <= d0_rdout;
        end
    end

    always @(posedge CLK12) begin
        if (do_init) begin
            mem1[13'h0123] <= 8'h5A; mem1[13'h0456] <= 8'h3C;
        end else if (!d1_wen) begin
            mem1[d1_raddr] <= d1_rdout;
        end
    end

    typedef struct {
        logic        csn, rwb;
        logic [12:0] addr;
        logic [7:0]  din;
        logic        vreq;
        logic [12:0] vaddr;
        logic        e_ack, e_wen, e_dtacn, e_vv;
        logic        ca;
        logic [12:0] e_addr;
        logic        cd;
        logic [7:0]  e_dout;
        logic [1:0]  dsel;
        logic [7:0]  e_data;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        input logic csn, input logic rwb, input logic [12:0] addr, input logic [7:0] din,
        input logic vreq, input logic [12:0] vaddr,
        input logic ack, input logic wen, input logic dtacn, input logic vv,
        input logic ca, input logic [12:0] eaddr, input logic cd, input logic [7:0] edout,
        input logic [1:0] dsel, input logic [7:0] edata);
        vec_t v;
        v.csn = csn; v.rwb = rwb; v.addr = addr; v.din = din; v.vreq = vreq; v.vaddr = vaddr;
        v.e_ack = ack; v.e_wen = wen; v.e_dtacn = dtacn; v.e_vv = vv;
        v.ca = ca; v.e_addr = eaddr; v.cd = cd; v.e_dout = edout; v.dsel = dsel; v.e_data = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK12);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " RAM_WEn"},   32'(d0_wen), 32'd1);
        chk({tag, " DTACn"},     32'(d0_dtacn), 32'd1);
        chk({tag, " VID_VALID"}, 32'(d0_vv), 32'd0);
        chk({tag, " VID_ACK"},   32'(d0_ack), 32'd0);
        chk({tag, " RAM_ADDR"},  32'(d0_raddr), 32'd0);
        chk({tag, " RAM_DOUT"},  32'(d0_rdout), 32'd0);
        chk({tag, " CPU_DOUT"},  32'(d0_cpu_dout), 32'd0);
        chk({tag, " VID_DATA"},  32'(d0_vid_data), 32'd0);
    endtask

    initial begin
        logic [7:0] h0, h1;
        //            csn rw addr      din    vr vaddr    ack wen dt vv  ca eaddr     cd dout   ds data
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 1, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 1, 0,  1, 13'h0123, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 0, 8'h00, 2, 8'h5A));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 0, 8'h00, 2, 8'h5A));
        tbl.push_back(mk(1, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 0, 13'h1FFF, 8'hA5, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 0, 13'h1FFF, 8'hA5, 0, 13'h000, 0, 0, 1, 0,  1, 13'h1FFF, 1, 8'hA5, 0, 8'h00));
        tbl.push_back(mk(0, 0, 13'h1FFF, 8'hA5, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 1, 8'hA5, 0, 8'h00));
        tbl.push_back(mk(1, 0, 13'h1FFF, 8'hA5, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 1, 13'h456, 1, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 1, 13'hAAA, 1, 1, 1, 0,  1, 13'h0456, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 1,  1, 13'h0AAA, 1, 8'hA5, 1, 8'h3C));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 1,  0, 13'h0000, 0, 8'h00, 1, 8'hC3));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 1, 13'h456, 1, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 1, 0,  1, 13'h0456, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 1, 1,  1, 13'h0123, 0, 8'h00, 1, 8'h3C));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 0, 8'h00, 2, 8'h5A));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 0, 13'h0010, 8'h77, 1, 13'h456, 1, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 0,  1, 13'h0456, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 1,  0, 13'h0000, 1, 8'hA5, 1, 8'h3C));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 0, 13'h0020, 8'h99, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 0, 13'h0020, 8'h99, 0, 13'h000, 0, 0, 1, 0,  1, 13'h0020, 1, 8'h99, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 1, 0,  1, 13'h0123, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(0, 1, 13'h0123, 8'h00, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 0, 8'h00, 2, 8'h5A));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 0, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));
        tbl.push_back(mk(1, 1, 13'h0000, 8'h00, 0, 13'h000, 0, 1, 1, 0,  0, 13'h0000, 0, 8'h00, 0, 8'h00));

        // Reset state, with a video request present to show VID_ACK is gated
        VID_REQ = 1'b1;
        step();
        step();
        chk_reset_state("rst");
        do_init = 1'b0;
        VID_REQ = 1'b0;
        step();
        RESET = 1'b0;

        foreach (tbl[i]) begin
            step();
            CPU_CSn = tbl[i].csn; CPU_RWb = tbl[i].rwb; CPU_ADDR = tbl[i].addr;
            CPU_DIN = tbl[i].din; VID_REQ = tbl[i].vreq; VID_ADDR = tbl[i].vaddr;
            #1;
            chk($sformatf("row%0d VID_ACK", i),   32'(d0_ack),   32'(tbl[i].e_ack));
            chk($sformatf("row%0d RAM_WEn", i),   32'(d0_wen),   32'(tbl[i].e_wen));
            chk($sformatf("row%0d DTACn", i),     32'(d0_dtacn), 32'(tbl[i].e_dtacn));
            chk($sformatf("row%0d VID_VALID", i), 32'(d0_vv),    32'(tbl[i].e_vv));
            if (tbl[i].ca)
                chk($sformatf("row%0d RAM_ADDR", i), 32'(d0_raddr), 32'(tbl[i].e_addr));
            if (tbl[i].cd)
                chk($sformatf("row%0d RAM_DOUT", i), 32'(d0_rdout), 32'(tbl[i].e_dout));
            if (tbl[i].dsel == 2'd1)
                chk($sformatf("row%0d VID_DATA", i), 32'(d0_vid_data), 32'(tbl[i].e_data));
            if (tbl[i].dsel == 2'd2)
                chk($sformatf("row%0d CPU_DOUT", i), 32'(d0_cpu_dout), 32'(tbl[i].e_data));
        end
        chk("mem write 1FFF", 32'(mem0[13'h1FFF]), 32'h0A5);
        chk("mem withdrawn 0010", 32'(mem0[13'h0010]), 32'h000);
        chk("mem late-abort 0020", 32'(mem0[13'h0020]), 32'h099);

        // Starvation: continuous video with a CPU read pending, MAX_VID=3 and 1
        step();
        CPU_CSn = 1'b0; CPU_RWb = 1'b1; CPU_ADDR = 13'h0123;
        VID_REQ = 1'b1; VID_ADDR = 13'h0456;
        h0 = '0;
        h1 = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            h0[k] = d0_ack;
            h1[k] = d1_ack;
            step();
        end
        chk("starve3 ack pattern", 32'(h0), 32'h0F7);
        chk("starve1 ack pattern", 32'(h1), 32'h0FD);
        chk("starve3 DTACn", 32'(d0_dtacn), 32'd0);
        chk("starve1 DTACn", 32'(d1_dtacn), 32'd0);
        chk("starve3 CPU_DOUT", 32'(d0_cpu_dout), 32'h05A);
        chk("starve1 CPU_DOUT", 32'(d1_cpu_dout), 32'h05A);
        CPU_CSn = 1'b1;
        VID_REQ = 1'b0;
        step();
        step();
        chk("starve3 DTACn release", 32'(d0_dtacn), 32'd1);
        chk("starve1 DTACn release", 32'(d1_dtacn), 32'd1);

        // Reset asserted while a CPU write is in its RAM cycle
        step();
        CPU_CSn = 1'b0; CPU_RWb = 1'b0; CPU_ADDR = 13'h0030; CPU_DIN = 8'h11;
        step();
        chk("wr N+1 RAM_WEn", 32'(d0_wen), 32'd0);
        #1;
        RESET = 1'b1;
        #1;
        chk_reset_state("midrst");
        step();
        CPU_CSn = 1'b1;
        step();
        chk("midrst no commit", 32'(mem0[13'h0030]), 32'h000);
        RESET = 1'b0;
        step();
        CPU_CSn = 1'b0; CPU_RWb = 1'b1; CPU_ADDR = 13'h0123;
        step();
        #1;
        chk("post-rst RAM_ADDR", 32'(d0_raddr), 32'h0123);
        step();
        chk("post-rst DTACn", 32'(d0_dtacn), 32'd0);
        chk("post-rst CPU_DOUT", 32'(d0_cpu_dout), 32'h05A);
        CPU_CSn = 1'b1;
        step();
        step();
        chk("post-rst DTACn release", 32'(d0_dtacn), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
